// File: rtl/demux16_collect.sv
// demux16_collect
// Bit-serial 1:N demultiplexing collector. Each accepted bit lands at word
// position sel and marks that position in fill_mask. Once every position has
// been written, the word is held on a valid/ready port. Input is
// back-pressured until the consumer takes the word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting bits, word_valid=0, in_ready=1
// HOLD    | word complete, word_valid=1, in_ready=0, waiting word_ready
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   bit_in, sel       data bit and destination position (sel=0 -> word[0])
//   in_valid/in_ready input handshake
//   word_out          assembled word
//   word_valid/ready  output handshake
//   fill_mask         positions written since last clear
//   fill_cnt          popcount of fill_mask
//   dup_err           one-cycle pulse after a write to an already-filled slot
module demux16_collect #(
   parameter int SEL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_in,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [(1<<SEL_W)-1:0] word_out,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic [(1<<SEL_W)-1:0] fill_mask,
   output logic [SEL_W:0]       fill_cnt,
   output logic                 dup_err
);

   localparam int N = 1 << SEL_W;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   word_q, word_d;
   logic [N-1:0]   mask_q, mask_d;
   logic [SEL_W:0] cnt_q, cnt_d;
   logic           dup_q, dup_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         word_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      dup_d   = 1'b0;
      case (state_q)
         COLLECT: begin
            // in_ready is 1 throughout COLLECT, so in_valid alone means accept
            if (in_valid) begin
               word_d[sel] = bit_in;
               if (mask_q[sel]) begin
                  dup_d = 1'b1;
               end else begin
                  mask_d[sel] = 1'b1;
                  cnt_d       = cnt_q + {{SEL_W{1'b0}}, 1'b1};
               end
               if (&mask_d) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (word_ready) begin
               word_d  = '0;
               mask_d  = '0;
               cnt_d   = '0;
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   assign word_valid = (state_q == HOLD);
   assign in_ready   = (state_q == COLLECT);
   assign word_out   = word_q;
   assign fill_mask  = mask_q;
   assign fill_cnt   = cnt_q;
   assign dup_err    = dup_q;

endmodule

// File: tb/tb_demux16_collect.sv
module tb_demux16_collect;

   localparam int SEL_W = 4;
   localparam int N     = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             bit_in;
   logic [SEL_W-1:0] sel;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     word_out;
   logic             word_valid;
   logic             word_ready;
   logic [N-1:0]     fill_mask;
   logic [SEL_W:0]   fill_cnt;
   logic             dup_err;

   int n_pass  = 0;
   int n_total = 0;

   demux16_collect #(.SEL_W(SEL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .sel        (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .fill_mask  (fill_mask),
      .fill_cnt   (fill_cnt),
      .dup_err    (dup_err)
   );

   always #5 clk = ~clk;

   // Reference model: which slots hold what, whether the word is parked.
   bit m_data    [N];
   bit m_written [N];
   bit m_full;
   bit m_dup;

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_data[i]    = 1'b0;
         m_written[i] = 1'b0;
      end
      m_full = 1'b0;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += m_written[i];
      return c;
   endfunction

   function automatic logic [N-1:0] model_word();
      logic [N-1:0] w;
      for (int i = 0; i < N; i++) w[i] = m_data[i];
      return w;
   endfunction

   function automatic logic [N-1:0] model_mask();
      logic [N-1:0] w;
      for (int i = 0; i < N; i++) w[i] = m_written[i];
      return w;
   endfunction

   function automatic void model_step();
      m_dup = 1'b0;
      if (rst) begin
         model_clear();
      end else if (m_full) begin
         if (word_ready) model_clear();
      end else if (in_valid) begin
         m_dup = m_written[sel];
         m_data[sel]    = bit_in;
         m_written[sel] = 1'b1;
         if (model_count() == N) m_full = 1'b1;
      end
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; in_valid = 1'b0; bit_in = 1'b0; sel = '0; word_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic write_bit(input int s, input logic b);
      in_valid = 1'b1; sel = SEL_W'(s); bit_in = b; tick(); in_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; in_valid = 1'b1; bit_in = 1'b1; sel = 4'd5;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0;
      n_total++;
      if ({word_out, fill_mask, fill_cnt, word_valid, in_ready, dup_err} !==
          {16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset: word=%h mask=%h cnt=%0d valid=%b ready=%b dup=%b, want 0/0/0/0/1/0",
                  word_out, fill_mask, fill_cnt, word_valid, in_ready, dup_err);
      else n_pass++;
   endtask

   task automatic test_ascending();
      logic [N-1:0] v;
      v = 16'hA5C3;
      for (int i = 0; i < N; i++) begin
         write_bit(i, v[i]);
         if (i == 14) begin
            n_total++;
            if (word_valid !== 1'b0 || fill_cnt !== 5'd15)
               $display("FAIL asc_early: valid=%b cnt=%0d, want 0 15", word_valid, fill_cnt);
            else n_pass++;
         end
      end
      n_total++;
      if (word_valid !== 1'b1 || word_out !== 16'hA5C3 || fill_cnt !== 5'd16 || in_ready !== 1'b0)
         $display("FAIL asc_done: valid=%b word=%h cnt=%0d ready=%b, want 1 a5c3 16 0",
                  word_valid, word_out, fill_cnt, in_ready);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0]; sel = SEL_W'($urandom_range(0, N-1)); bit_in = $urandom_range(0, 1);
         tick();
         n_total++;
         if (word_out !== 16'hA5C3 || word_valid !== 1'b1 || dup_err !== 1'b0 || fill_mask !== 16'hFFFF)
            $display("FAIL asc_hold: word=%h valid=%b dup=%b mask=%h, want a5c3 1 0 ffff",
                     word_out, word_valid, dup_err, fill_mask);
         else n_pass++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_handshake();
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      n_total++;
      if (word_valid !== 1'b0 || word_out !== 16'h0 || fill_mask !== 16'h0 || in_ready !== 1'b1)
         $display("FAIL hs_clear: valid=%b word=%h mask=%h ready=%b, want 0 0 0 1",
                  word_valid, word_out, fill_mask, in_ready);
      else n_pass++;
      write_bit(15, 1'b1);
      n_total++;
      if (fill_mask !== 16'h8000 || fill_cnt !== 5'd1)
         $display("FAIL hs_write: mask=%h cnt=%0d, want 8000 1", fill_mask, fill_cnt);
      else n_pass++;
   endtask

   task automatic test_duplicate();
      do_reset();
      write_bit(3, 1'b1);
      n_total++;
      if (dup_err !== 1'b0)
         $display("FAIL dup_first: dup=%b, want 0", dup_err);
      else n_pass++;
      write_bit(3, 1'b0);
      n_total++;
      if (dup_err !== 1'b1 || fill_cnt !== 5'd1)
         $display("FAIL dup_pulse: dup=%b cnt=%0d, want 1 1", dup_err, fill_cnt);
      else n_pass++;
      for (int s = N-1; s >= 0; s--) begin
         if (s != 3) begin
            write_bit(s, 1'b1);
            if (s == N-1) begin
               n_total++;
               if (dup_err !== 1'b0)
                  $display("FAIL dup_single: dup=%b, want 0", dup_err);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (word_valid !== 1'b1 || word_out !== 16'hFFF7)
         $display("FAIL dup_word: valid=%b word=%h, want 1 fff7", word_valid, word_out);
      else n_pass++;
      word_ready = 1'b1; tick(); word_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] v;
      for (int i = 0; i < 9; i++) write_bit(i * 7 % N, 1'b1);
      n_total++;
      if (fill_cnt !== 5'd9)
         $display("FAIL mid_cnt: cnt=%0d, want 9", fill_cnt);
      else n_pass++;
      do_reset();
      n_total++;
      if ({word_out, fill_mask, fill_cnt, word_valid, dup_err} !== {16'h0, 16'h0, 5'd0, 1'b0, 1'b0})
         $display("FAIL mid_reset: word=%h mask=%h cnt=%0d valid=%b dup=%b, want all 0",
                  word_out, fill_mask, fill_cnt, word_valid, dup_err);
      else n_pass++;
      v = 16'h1234;
      for (int i = 0; i < N; i++) write_bit(i, v[i]);
      n_total++;
      if (word_valid !== 1'b1 || word_out !== 16'h1234)
         $display("FAIL mid_word: valid=%b word=%h, want 1 1234", word_valid, word_out);
      else n_pass++;
      word_ready = 1'b1; tick(); word_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] words [2];
      int           pulse_at [$];
      logic [N-1:0] pulse_word [$];
      words[0] = 16'hFFFF;
      words[1] = 16'h0001;
      word_ready = 1'b1;
      for (int c = 0; c < 36; c++) begin
         if (c < 16)                begin in_valid = 1'b1; sel = SEL_W'(c);      bit_in = words[0][c];      end
         else if (c >= 17 && c < 33) begin in_valid = 1'b1; sel = SEL_W'(c - 17); bit_in = words[1][c - 17]; end
         else                        in_valid = 1'b0;
         tick();
         if (word_valid === 1'b1) begin
            pulse_at.push_back(c);
            pulse_word.push_back(word_out);
         end
      end
      idle_inputs();
      n_total++;
      if (pulse_at.size() != 2)
         $display("FAIL b2b_count: pulses=%0d, want 2", pulse_at.size());
      else begin
         n_pass++;
         n_total++;
         if (pulse_at[1] - pulse_at[0] != N + 1)
            $display("FAIL b2b_gap: gap=%0d, want %0d", pulse_at[1] - pulse_at[0], N + 1);
         else n_pass++;
         n_total++;
         if (pulse_word[0] !== 16'hFFFF || pulse_word[1] !== 16'h0001)
            $display("FAIL b2b_words: got %h %h, want ffff 0001", pulse_word[0], pulse_word[1]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         sel        = SEL_W'($urandom_range(0, N-1));
         bit_in     = $urandom_range(0, 1);
         word_ready = ($urandom_range(0, 2) == 0);
         tick();
         n_total++;
         if ({word_out, fill_mask, fill_cnt, word_valid, in_ready, dup_err} !==
             {model_word(), model_mask(), 5'(model_count()), m_full, !m_full, m_dup}) begin
            if (errs < 10)
               $display("FAIL random c=%0d: word=%h mask=%h cnt=%0d valid=%b ready=%b dup=%b, want %h %h %0d %b %b %b",
                        c, word_out, fill_mask, fill_cnt, word_valid, in_ready, dup_err,
                        model_word(), model_mask(), model_count(), m_full, !m_full, m_dup);
            errs++;
         end else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      model_clear();
      m_dup = 1'b0;
      test_reset();
      test_ascending();
      test_handshake();
      test_duplicate();
      test_reset_mid();
      do_reset();
      test_back_to_back();
      do_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
